// File: rtl/brg_xcel_resp_reorder.sv
// brg_xcel_resp_reorder
//   Reorder buffer for remote-load responses. The issuer allocates a load id
//   (the tail slot index) for each outgoing load. The endpoint returns
//   responses tagged with that id in any order. Data is released to the
//   consumer strictly in allocation order.
//
// Ports
//   clk_i, reset_i            clock, synchronous active-high reset
//   alloc_v_i / alloc_ready_o allocation handshake
//   alloc_id_o                id for the next allocation (tail, zero-extended)
//   resp_v_i, resp_id_i,      returned load; always accepted
//   resp_data_i
//   out_v_o, out_data_o       oldest load's data, valid once filled
//   out_yumi_i                consumer takes out_data_o
//   outstanding_o             allocated, not yet dequeued slots
//   err_o                     sticky protocol error (checking build only)
//
// Build option
//   BRG_XCEL_REORDER_CHECK_EN: when defined, invalid responses and yumi on an
//   empty head are discarded and latch err_o until reset. When undefined,
//   err_o is 0 and every response writes the slot named by its low id bits.

module brg_xcel_resp_reorder #(
  parameter int data_width_p    = 32,
  parameter int load_id_width_p = 11,
  parameter int els_p           = 8
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           alloc_v_i,
  output logic                           alloc_ready_o,
  output logic [load_id_width_p-1:0]     alloc_id_o,
  input  logic                           resp_v_i,
  input  logic [load_id_width_p-1:0]     resp_id_i,
  input  logic [data_width_p-1:0]        resp_data_i,
  output logic                           out_v_o,
  output logic [data_width_p-1:0]        out_data_o,
  input  logic                           out_yumi_i,
  output logic [$clog2(els_p+1)-1:0]     outstanding_o,
  output logic                           err_o
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [els_p-1:0]        alloc_q, alloc_d;
  logic [els_p-1:0]        filled_q, filled_d;
  logic [ptr_w_lp-1:0]     head_q, head_d;
  logic [ptr_w_lp-1:0]     tail_q, tail_d;
  logic [cnt_w_lp-1:0]     cnt_q, cnt_d;
  logic [data_width_p-1:0] data_q [els_p];

  logic                    alloc_fire;
  logic                    deq_fire;
  logic                    resp_we;
  logic [ptr_w_lp-1:0]     resp_idx;

  assign resp_idx      = resp_id_i[ptr_w_lp-1:0];
  // Readiness comes from registered count only, so a same-cycle dequeue
  // never opens a slot for allocation in that cycle.
  assign alloc_ready_o = (cnt_q < cnt_w_lp'(els_p));
  assign alloc_id_o    = load_id_width_p'(tail_q);
  assign out_v_o       = alloc_q[head_q] & filled_q[head_q];
  assign out_data_o    = data_q[head_q];
  assign outstanding_o = cnt_q;

  assign alloc_fire    = alloc_v_i & alloc_ready_o;
  assign deq_fire      = out_yumi_i & out_v_o;

`ifdef BRG_XCEL_REORDER_CHECK_EN
  logic resp_ok;
  logic err_q, err_d;

  assign resp_ok = ((resp_id_i >> ptr_w_lp) == '0)
                 & alloc_q[resp_idx] & ~filled_q[resp_idx];
  assign resp_we = resp_v_i & resp_ok;
  assign err_d   = err_q | (resp_v_i & ~resp_ok) | (out_yumi_i & ~out_v_o);
  assign err_o   = err_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) err_q <= 1'b0;
    else         err_q <= err_d;
  end
`else
  logic unused_resp_hi;

  assign unused_resp_hi = |(resp_id_i >> ptr_w_lp);
  assign resp_we        = resp_v_i;
  assign err_o          = 1'b0;
`endif

  // Ordering: a response sets filled, then a dequeue clears the head slot,
  // then an allocation claims the tail slot with filled cleared (a freshly
  // allocated load cannot yet have a legitimate response).
  always_comb begin
    alloc_d  = alloc_q;
    filled_d = filled_q;
    head_d   = head_q;
    tail_d   = tail_q;
    cnt_d    = cnt_q;
    if (resp_we) filled_d[resp_idx] = 1'b1;
    if (deq_fire) begin
      alloc_d[head_q]  = 1'b0;
      filled_d[head_q] = 1'b0;
      head_d           = head_q + 1'b1;
    end
    if (alloc_fire) begin
      alloc_d[tail_q]  = 1'b1;
      filled_d[tail_q] = 1'b0;
      tail_d           = tail_q + 1'b1;
    end
    case ({alloc_fire, deq_fire})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      alloc_q  <= '0;
      filled_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      cnt_q    <= '0;
    end else begin
      alloc_q  <= alloc_d;
      filled_q <= filled_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      cnt_q    <= cnt_d;
    end
  end

  // Data storage carries no reset; validity is tracked by the filled bits.
  always_ff @(posedge clk_i) begin
    if (resp_we) data_q[resp_idx] <= resp_data_i;
  end

endmodule

// File: tb/tb_brg_xcel_resp_reorder.sv
module tb_brg_xcel_resp_reorder;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        alloc_v_i;
  logic        alloc_ready_o;
  logic [10:0] alloc_id_o;
  logic        resp_v_i;
  logic [10:0] resp_id_i;
  logic [31:0] resp_data_i;
  logic        out_v_o;
  logic [31:0] out_data_o;
  logic        out_yumi_i;
  logic [3:0]  outstanding_o;
  logic        err_o;

  int checks   = 0;
  int failures = 0;

  brg_xcel_resp_reorder #(
    .data_width_p   (32),
    .load_id_width_p(11),
    .els_p          (8)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .alloc_v_i    (alloc_v_i),
    .alloc_ready_o(alloc_ready_o),
    .alloc_id_o   (alloc_id_o),
    .resp_v_i     (resp_v_i),
    .resp_id_i    (resp_id_i),
    .resp_data_i  (resp_data_i),
    .out_v_o      (out_v_o),
    .out_data_o   (out_data_o),
    .out_yumi_i   (out_yumi_i),
    .outstanding_o(outstanding_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    cyc();
    reset_i = 1'b0;
  endtask

  task automatic do_resp(input logic [10:0] id, input logic [31:0] d);
    resp_v_i    = 1'b1;
    resp_id_i   = id;
    resp_data_i = d;
    cyc();
    resp_v_i    = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    cyc();
    cyc();
    reset_i = 1'b0;
    checks++; if (alloc_ready_o !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0b exp=1", alloc_ready_o); end
    checks++; if (alloc_id_o !== 11'd0) begin failures++; $display("FAIL rst_id got=%0d exp=0", alloc_id_o); end
    checks++; if (out_v_o !== 1'b0) begin failures++; $display("FAIL rst_out_v got=%0b exp=0", out_v_o); end
    checks++; if (outstanding_o !== 4'd0) begin failures++; $display("FAIL rst_outstanding got=%0d exp=0", outstanding_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL rst_err got=%0b exp=0", err_o); end
  endtask

  task automatic test_in_order();
    logic [31:0] exp_d;
    do_reset();
    alloc_v_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (alloc_id_o !== 11'(i)) begin failures++; $display("FAIL inord_id got=%0d exp=%0d", alloc_id_o, i); end
      cyc();
    end
    alloc_v_i = 1'b0;
    checks++; if (outstanding_o !== 4'd3) begin failures++; $display("FAIL inord_cnt got=%0d exp=3", outstanding_o); end
    for (int i = 0; i < 3; i++) begin
      exp_d       = 32'hA0 + 32'(i);
      resp_v_i    = 1'b1;
      resp_id_i   = 11'(i);
      resp_data_i = exp_d;
      #1;
      checks++; if (out_v_o !== 1'b0) begin failures++; $display("FAIL inord_nobypass got=%0b exp=0", out_v_o); end
      cyc();
      resp_v_i = 1'b0;
      checks++; if (out_v_o !== 1'b1) begin failures++; $display("FAIL inord_v got=%0b exp=1", out_v_o); end
      checks++; if (out_data_o !== exp_d) begin failures++; $display("FAIL inord_data got=%h exp=%h", out_data_o, exp_d); end
      out_yumi_i = 1'b1;
      cyc();
      out_yumi_i = 1'b0;
    end
    checks++; if (outstanding_o !== 4'd0) begin failures++; $display("FAIL inord_cnt_end got=%0d exp=0", outstanding_o); end
    checks++; if (out_v_o !== 1'b0) begin failures++; $display("FAIL inord_v_end got=%0b exp=0", out_v_o); end
  endtask

  task automatic test_reorder();
    logic [31:0] exp_q [4];
    exp_q[0] = 32'h00; exp_q[1] = 32'h11; exp_q[2] = 32'h22; exp_q[3] = 32'h33;
    do_reset();
    alloc_v_i = 1'b1;
    repeat (4) cyc();
    alloc_v_i = 1'b0;
    do_resp(11'd3, 32'h33);
    checks++; if (out_v_o !== 1'b0) begin failures++; $display("FAIL reord_v_after3 got=%0b exp=0", out_v_o); end
    do_resp(11'd1, 32'h11);
    checks++; if (out_v_o !== 1'b0) begin failures++; $display("FAIL reord_v_after1 got=%0b exp=0", out_v_o); end
    do_resp(11'd0, 32'h00);
    checks++; if (out_v_o !== 1'b1) begin failures++; $display("FAIL reord_v_after0 got=%0b exp=1", out_v_o); end
    do_resp(11'd2, 32'h22);
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_v_o !== 1'b1) begin failures++; $display("FAIL reord_v%0d got=%0b exp=1", k, out_v_o); end
      checks++; if (out_data_o !== exp_q[k]) begin failures++; $display("FAIL reord_data%0d got=%h exp=%h", k, out_data_o, exp_q[k]); end
      out_yumi_i = 1'b1;
      cyc();
      out_yumi_i = 1'b0;
    end
    checks++; if (out_v_o !== 1'b0) begin failures++; $display("FAIL reord_v_end got=%0b exp=0", out_v_o); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    alloc_v_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (alloc_id_o !== 11'(i)) begin failures++; $display("FAIL full_id got=%0d exp=%0d", alloc_id_o, i); end
      cyc();
    end
    checks++; if (alloc_ready_o !== 1'b0) begin failures++; $display("FAIL full_ready got=%0b exp=0", alloc_ready_o); end
    checks++; if (outstanding_o !== 4'd8) begin failures++; $display("FAIL full_cnt got=%0d exp=8", outstanding_o); end
    do_resp(11'd0, 32'h5A);
    checks++; if (outstanding_o !== 4'd8) begin failures++; $display("FAIL full_hold_cnt got=%0d exp=8", outstanding_o); end
    checks++; if (out_data_o !== 32'h5A) begin failures++; $display("FAIL full_head_data got=%h exp=5a", out_data_o); end
    out_yumi_i = 1'b1;
    cyc();
    out_yumi_i = 1'b0;
    checks++; if (outstanding_o !== 4'd7) begin failures++; $display("FAIL full_yumi_cnt got=%0d exp=7", outstanding_o); end
    checks++; if (alloc_ready_o !== 1'b1) begin failures++; $display("FAIL full_ready_after got=%0b exp=1", alloc_ready_o); end
    checks++; if (alloc_id_o !== 11'd0) begin failures++; $display("FAIL full_wrap_id got=%0d exp=0", alloc_id_o); end
    cyc();
    alloc_v_i = 1'b0;
    checks++; if (outstanding_o !== 4'd8) begin failures++; $display("FAIL full_realloc_cnt got=%0d exp=8", outstanding_o); end
    checks++; if (alloc_id_o !== 11'd1) begin failures++; $display("FAIL full_tail_id got=%0d exp=1", alloc_id_o); end
  endtask

  task automatic test_concurrent();
    do_reset();
    alloc_v_i = 1'b1;
    repeat (2) cyc();
    alloc_v_i = 1'b0;
    do_resp(11'd0, 32'hC0);
    alloc_v_i   = 1'b1;
    out_yumi_i  = 1'b1;
    resp_v_i    = 1'b1;
    resp_id_i   = 11'd1;
    resp_data_i = 32'hC1;
    cyc();
    alloc_v_i  = 1'b0;
    out_yumi_i = 1'b0;
    resp_v_i   = 1'b0;
    checks++; if (outstanding_o !== 4'd2) begin failures++; $display("FAIL conc_cnt got=%0d exp=2", outstanding_o); end
    checks++; if (out_v_o !== 1'b1) begin failures++; $display("FAIL conc_v got=%0b exp=1", out_v_o); end
    checks++; if (out_data_o !== 32'hC1) begin failures++; $display("FAIL conc_data got=%h exp=c1", out_data_o); end
    checks++; if (alloc_id_o !== 11'd3) begin failures++; $display("FAIL conc_id got=%0d exp=3", alloc_id_o); end
    out_yumi_i = 1'b1;
    cyc();
    out_yumi_i = 1'b0;
    checks++; if (out_v_o !== 1'b0) begin failures++; $display("FAIL conc_v2 got=%0b exp=0", out_v_o); end
    do_resp(11'd2, 32'hC2);
    checks++; if (out_data_o !== 32'hC2) begin failures++; $display("FAIL conc_data2 got=%h exp=c2", out_data_o); end
  endtask

  task automatic test_error();
    logic        exp_err;
    logic [31:0] exp_dup;
`ifdef BRG_XCEL_REORDER_CHECK_EN
    exp_err = 1'b1;
    exp_dup = 32'hD0;
`else
    exp_err = 1'b0;
    exp_dup = 32'hDD;
`endif
    do_reset();
    resp_v_i    = 1'b1;
    resp_id_i   = 11'd5;
    resp_data_i = 32'hEE;
    #1;
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL err_pre got=%0b exp=0", err_o); end
    cyc();
    resp_v_i = 1'b0;
    checks++; if (err_o !== exp_err) begin failures++; $display("FAIL err_unalloc got=%0b exp=%0b", err_o, exp_err); end
    checks++; if (out_v_o !== 1'b0) begin failures++; $display("FAIL err_unalloc_v got=%0b exp=0", out_v_o); end
    do_reset();
    alloc_v_i = 1'b1;
    cyc();
    alloc_v_i = 1'b0;
    do_resp(11'd0, 32'hD0);
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL err_first got=%0b exp=0", err_o); end
    do_resp(11'd0, 32'hDD);
    checks++; if (err_o !== exp_err) begin failures++; $display("FAIL err_dup got=%0b exp=%0b", err_o, exp_err); end
    checks++; if (out_data_o !== exp_dup) begin failures++; $display("FAIL err_dup_data got=%h exp=%h", out_data_o, exp_dup); end
    checks++; if (out_v_o !== 1'b1) begin failures++; $display("FAIL err_dup_v got=%0b exp=1", out_v_o); end
    out_yumi_i = 1'b1;
    cyc();
    out_yumi_i = 1'b0;
    checks++; if (outstanding_o !== 4'd0) begin failures++; $display("FAIL err_deq_cnt got=%0d exp=0", outstanding_o); end
    do_reset();
    out_yumi_i = 1'b1;
    cyc();
    out_yumi_i = 1'b0;
    checks++; if (err_o !== exp_err) begin failures++; $display("FAIL err_yumi got=%0b exp=%0b", err_o, exp_err); end
    checks++; if (outstanding_o !== 4'd0) begin failures++; $display("FAIL err_yumi_cnt got=%0d exp=0", outstanding_o); end
  endtask

  task automatic test_reset_midflight();
    logic exp_err;
`ifdef BRG_XCEL_REORDER_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    do_reset();
    alloc_v_i = 1'b1;
    repeat (3) cyc();
    alloc_v_i = 1'b0;
    do_resp(11'd0, 32'hB0);
    checks++; if (out_v_o !== 1'b1) begin failures++; $display("FAIL mid_v_pre got=%0b exp=1", out_v_o); end
    do_reset();
    checks++; if (out_v_o !== 1'b0) begin failures++; $display("FAIL mid_v got=%0b exp=0", out_v_o); end
    checks++; if (outstanding_o !== 4'd0) begin failures++; $display("FAIL mid_cnt got=%0d exp=0", outstanding_o); end
    checks++; if (alloc_id_o !== 11'd0) begin failures++; $display("FAIL mid_id got=%0d exp=0", alloc_id_o); end
    do_resp(11'd1, 32'hB1);
    checks++; if (out_v_o !== 1'b0) begin failures++; $display("FAIL mid_late_v got=%0b exp=0", out_v_o); end
    checks++; if (err_o !== exp_err) begin failures++; $display("FAIL mid_late_err got=%0b exp=%0b", err_o, exp_err); end
    alloc_v_i = 1'b1;
    repeat (2) cyc();
    alloc_v_i = 1'b0;
    checks++; if (out_v_o !== 1'b0) begin failures++; $display("FAIL mid_realloc_v got=%0b exp=0", out_v_o); end
    do_resp(11'd0, 32'hB2);
    checks++; if (out_data_o !== 32'hB2) begin failures++; $display("FAIL mid_new_data got=%h exp=b2", out_data_o); end
    out_yumi_i = 1'b1;
    cyc();
    out_yumi_i = 1'b0;
    checks++; if (out_v_o !== 1'b0) begin failures++; $display("FAIL mid_dropped_v got=%0b exp=0", out_v_o); end
    checks++; if (outstanding_o !== 4'd1) begin failures++; $display("FAIL mid_end_cnt got=%0d exp=1", outstanding_o); end
  endtask

  initial begin
    reset_i     = 1'b1;
    alloc_v_i   = 1'b0;
    resp_v_i    = 1'b0;
    resp_id_i   = '0;
    resp_data_i = '0;
    out_yumi_i  = 1'b0;
    test_reset();
    test_in_order();
    test_reorder();
    test_full_wrap();
    test_concurrent();
    test_error();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/brg_xcel_resp_reorder.md
BRG_XCEL_RESP_REORDER -- requirements
Module: brg_xcel_resp_reorder

Interface
REQ-001 SHALL have parameter data_width_p, default 32, width of the response data word.
REQ-002 SHALL have parameter load_id_width_p, default 11, width of the endpoint load id.
REQ-003 SHALL have parameter els_p, default 8, number of reorder slots; power of 2, 2 <= els_p <= 2^load_id_width_p.
REQ-004 SHALL have port clk_i  input  1  single clock, all state updated on the rising edge.
REQ-005 SHALL have port reset_i  input  1  synchronous, active-high reset.
REQ-006 SHALL have port alloc_v_i  input  1  issuer requests a load id for an outgoing remote load.
REQ-007 SHALL have port alloc_ready_o  output  1  slot available; an allocation occurs when alloc_v_i & alloc_ready_o.
REQ-008 SHALL have port alloc_id_o  output  load_id_width_p  id to place in the load packet; tail index zero-extended.
REQ-009 SHALL have port resp_v_i  input  1  endpoint returned-data valid; always accepted, no back-pressure.
REQ-010 SHALL have port resp_id_i  input  load_id_width_p  returned load id.
REQ-011 SHALL have port resp_data_i  input  data_width_p  returned load data.
REQ-012 SHALL have port out_v_o  output  1  oldest allocated load has data.
REQ-013 SHALL have port out_data_o  output  data_width_p  data of the oldest load.
REQ-014 SHALL have port out_yumi_i  input  1  consumer takes out_data_o; legal only when out_v_o is 1.
REQ-015 SHALL have port outstanding_o  output  clog2(els_p+1)  number of allocated, not yet dequeued slots.
REQ-016 SHALL have port err_o  output  1  sticky protocol-error flag.

Function
REQ-017 SHALL keep per slot an allocated bit, a filled bit and a data_width_p data register, plus head and tail pointers of clog2(els_p) bits that wrap from els_p-1 to 0.
REQ-018 SHALL drive alloc_ready_o = (outstanding_o < els_p) from registered state only; a same-cycle dequeue does not free a slot for allocation that cycle.
REQ-019 On allocation SHALL set the tail slot's allocated bit, clear its filled bit, increment tail, and increment the count.
REQ-020 On a valid response, the response SHALL be valid when resp_id_i upper bits (above clog2(els_p)) are zero, the indexed slot is allocated, and the slot is not filled; a valid response writes resp_data_i and sets filled.
REQ-021 SHALL drive out_v_o = allocated[head] & filled[head] and out_data_o = data[head]; a response written in cycle t is visible on out_v_o in cycle t+1 (one-cycle latency, no bypass).
REQ-022 On out_yumi_i SHALL clear allocated and filled bits of the head slot, increment head, and decrement the count.
REQ-023 Simultaneous allocation and dequeue SHALL leave the count unchanged; simultaneous allocation, dequeue and response to distinct slots SHALL all take effect.
REQ-024 Responses arriving in any order SHALL be delivered on out_data_o strictly in allocation order.
REQ-025 out_yumi_i while out_v_o is 0 SHALL be ignored, and SHALL set err_o when checking is enabled.

Reset
REQ-026 On reset_i SHALL clear head, tail, count, all allocated and filled bits, and err_o; data registers are not reset.
REQ-027 Reset values SHALL be alloc_ready_o=1, alloc_id_o=0, out_v_o=0, outstanding_o=0, err_o=0; out_data_o is undefined.
REQ-028 Reset mid-operation SHALL drop all outstanding loads; responses arriving afterwards for dropped ids are treated per REQ-020 (invalid).

Configuration
REQ-029 Macro BRG_XCEL_REORDER_CHECK_EN SHALL control checking. With it defined, invalid responses (REQ-020) and illegal yumi (REQ-025) are discarded and set err_o until reset. Without it, err_o is tied to 0 and every response writes its slot (index taken from the low bits) and sets filled, without checks.

Verification
REQ-030 The bench SHALL cover in-order traffic: allocate ids 0,1,2, respond 0xA0,0xA1,0xA2 in order, yumi each. Required: out_data 0xA0,0xA1,0xA2, each appearing one cycle after its response.
REQ-031 The bench SHALL cover reordering: allocate 0..3, respond id3=0x33, id1=0x11, id0=0x00, id2=0x22. Required: out_v_o stays 0 until id0 arrives, then 0x00,0x11,0x22,0x33 in order.
REQ-032 The bench SHALL cover full and wrap with els_p=8: allocate 8, then confirm alloc_ready_o=0. Hold alloc_v_i with a yumi in the same cycle: no allocation that cycle, and the next cycle issues id 0 (the wrapped tail).
REQ-033 The bench SHALL cover error handling with checking enabled: respond id 5 with none allocated, or respond id 0 twice. Required: err_o=1 from the next cycle, slot data unchanged, out stream unaffected.
REQ-034 The bench SHALL cover reset mid-flight: allocate 0..2, respond id 0, then assert reset for 1 cycle. Required: out_v_o=0, outstanding_o=0, next alloc_id_o=0, and a late response id 1 is discarded.
